// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data RAM between the MEM stage and a DMA master with a starvation guard
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_ubhw,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic [2:0]        dma_ubhw,
  output logic              dma_gnt,
  output logic [31:0]       dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic [2:0]        ram_ubhw,
  input  logic [31:0]       ram_rdata
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [1:0] OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_DMA = 2'b10;
  logic [3:0] starve_cnt;
  logic [1:0] rd_owner;
  logic       cpu_gnt;
  assign dma_gnt   = dma_req & (~cpu_req | starve_cnt == LIMIT);
  assign cpu_gnt   = cpu_req & ~dma_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  // Idle cycles leave the CPU fields on the bus; only the write strobe is gated.
  assign ram_addr  = dma_gnt ? dma_addr : cpu_addr;
  assign ram_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign ram_ubhw  = dma_gnt ? dma_ubhw : cpu_ubhw;
  assign ram_we    = dma_gnt ? dma_we : cpu_gnt & cpu_we;
  assign cpu_rvalid = rd_owner == OWN_CPU;
  assign dma_rvalid = rd_owner == OWN_DMA;
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      starve_cnt <= (!dma_req || dma_gnt) ? 4'd0 :
                    (cpu_gnt && starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
      rd_owner   <= (dma_gnt && !dma_we) ? OWN_DMA :
                    (cpu_gnt && !cpu_we) ? OWN_CPU : OWN_NONE;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with a queue scoreboard for read returns
module tb_dmem_port_arbiter;
  logic        clk = 0, rst = 0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [2:0]  cpu_ubhw = 3'b010, dma_ubhw = 3'b010;
  logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, ram_we;
  logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [2:0]  ram_ubhw;
  logic [31:0] mem [0:255];
  logic [31:0] cpu_q[$], dma_q[$];
  int total = 0, bad = 0;
  logic pend = 0;

  dmem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ubhw(cpu_ubhw), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ubhw(dma_ubhw), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ubhw(ram_ubhw),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Read-first synchronous single-port RAM, word addressed
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[9:2]];
  end

  // DMA request must be held until granted
  always @(posedge clk) begin
    if (rst && pend) assert (dma_req) else $error("dma_req dropped before grant");
    pend <= rst & dma_req & ~dma_gnt;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected read data whenever a return is presented
  always @(negedge clk) begin
    if (cpu_rvalid || dma_rvalid) chk("rvalid_excl", 32'(cpu_rvalid & dma_rvalid), 0);
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_unexpected_rvalid", 1, 0);
      else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (dma_rvalid) begin
      if (dma_q.size() == 0) chk("dma_unexpected_rvalid", 1, 0);
      else chk("dma_rdata", dma_rdata, dma_q.pop_front());
    end
  end

  task automatic drive(input logic cr, cw, input logic [31:0] ca, cd,
                       input logic dr, dw, input logic [31:0] da, dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEAD_BEEF;
    mem[8'h0C] = 32'hA0A0_3030;
    mem[8'h10] = 32'hB0B0_4040;
    mem[8'h14] = 32'h5555_0000;
    @(negedge clk);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst_dma_gnt", 32'(dma_gnt), 0);
    tick(); rst = 1;
    // CPU only
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0); cpu_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_stall", 32'(cpu_stall), 0);
    chk("t1_ram_we", 32'(ram_we), 0);
    chk("t1_ram_addr", ram_addr, 32'h10);
    tick(); idle();
    @(negedge clk);
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t1_dma_rvalid", 32'(dma_rvalid), 0);
    tick();
    // DMA only
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234);
    @(negedge clk);
    chk("t2_wr_gnt", 32'(dma_gnt), 1);
    chk("t2_wr_we", 32'(ram_we), 1);
    chk("t2_wr_stall", 32'(cpu_stall), 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0); dma_q.push_back(32'h1234);
    @(negedge clk);
    chk("t2_rd_gnt", 32'(dma_gnt), 1);
    chk("t2_rd_we", 32'(ram_we), 0);
    tick(); idle();
    @(negedge clk);
    chk("t2_dma_rvalid", 32'(dma_rvalid), 1);
    chk("t2_stall", 32'(cpu_stall), 0);
    tick();
    // Contention: C,C,C,C,D,C,C,C,C,D,C,C then DMA drains when CPU goes idle
    for (int i = 0; i < 13; i++) begin
      automatic logic exp_d = (i == 4 || i == 9 || i == 12);
      drive(i < 12, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      if (exp_d) dma_q.push_back(32'h1234); else cpu_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk($sformatf("t3_gnt%0d", i), 32'(dma_gnt), 32'(exp_d));
      chk($sformatf("t3_stall%0d", i), 32'(cpu_stall), 32'(exp_d && i < 12));
      tick();
    end
    idle(); tick();
    // Return tagging: CPU read 0x30 on the 4th contended cycle, DMA 0x40 forced next
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, (i == 3) ? 32'h30 : 32'h10, 0, i < 5, 0, 32'h40, 0);
      if (i == 4) dma_q.push_back(32'hB0B0_4040);
      else cpu_q.push_back((i == 3) ? 32'hA0A0_3030 : 32'hDEAD_BEEF);
      @(negedge clk);
      if (i == 4) begin
        chk("t4_cpu_rv", 32'(cpu_rvalid), 1);
        chk("t4_dma_gnt", 32'(dma_gnt), 1);
      end
      if (i == 5) begin
        chk("t4_dma_rv", 32'(dma_rvalid), 1);
        chk("t4_cpu_rv_off", 32'(cpu_rvalid), 0);
      end
      tick();
    end
    idle(); tick(); tick();
    // Reset asserted before the return edge of a granted DMA read
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
    @(negedge clk);
    chk("t5_gnt", 32'(dma_gnt), 1);
    rst = 0;
    tick(); idle();
    @(negedge clk);
    chk("t5_rv_in_rst", 32'(dma_rvalid), 0);
    rst = 1;
    tick();
    @(negedge clk);
    chk("t5_rv_after", 32'(dma_rvalid), 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(i < 4 ? 1'b1 : 1'b0, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      if (i == 4) dma_q.push_back(32'h1234); else cpu_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk($sformatf("t5_gnt%0d", i), 32'(dma_gnt), 32'(i == 4));
      tick();
    end
    idle(); tick();
    // Write isolation: CPU store to 0x50 stalled by forced DMA read of 0x50
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 0, 32'h10, 0, 1, 0, 32'h50, 0);
      else if (i == 4) drive(1, 1, 32'h50, 32'h7777_7777, 1, 0, 32'h50, 0);
      else drive(1, 1, 32'h50, 32'h7777_7777, 0, 0, 0, 0);
      if (i < 4) cpu_q.push_back(32'hDEAD_BEEF);
      if (i == 4) dma_q.push_back(32'h5555_0000);
      @(negedge clk);
      if (i == 4) begin
        chk("t6_stall", 32'(cpu_stall), 1);
        chk("t6_dma_we", 32'(ram_we), 0);
      end
      if (i == 5) begin
        chk("t6_cpu_we", 32'(ram_we), 1);
        chk("t6_cpu_stall", 32'(cpu_stall), 0);
      end
      tick();
    end
    drive(1, 0, 32'h50, 0, 0, 0, 0, 0); cpu_q.push_back(32'h7777_7777);
    tick(); idle(); tick(); tick();
    chk("cpu_q_empty", 32'(cpu_q.size()), 0);
    chk("dma_q_empty", 32'(dma_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
